// File: rtl/ofm_drain_ctrl_pkg.sv
// Shared types and width helpers for the OFM drain controller and its column FIFO.
package ofm_drain_ctrl_pkg;

  localparam int DEF_DATA_WIDTH    = 8;
  localparam int DEF_SYSTOLIC_SIZE = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FLUSH = 2'd2,
    ST_CLEAR = 2'd3
  } drain_state_t;

  // Each ofm lane carries a full-precision product sum: twice the operand width.
  function automatic int lane_w(input int data_width);
    return 2 * data_width;
  endfunction

  function automatic int col_w(input int systolic_size);
    return (systolic_size > 1) ? $clog2(systolic_size) : 1;
  endfunction

endpackage

// File: rtl/ofm_drain_ctrl_fifo.sv
// Column FIFO for the drain stage: synchronous, simultaneous write/pop, head shown combinationally.
module ofm_col_fifo #(
  parameter int WIDTH = 260,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_wr;
  logic             do_rd;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  // Empty head reads as zero so the output bus is clean after reset and between drains.
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ofm_drain_ctrl.sv
// Drain controller: shifts N columns out of the PE array into a column FIFO, clears the array,
// and streams columns downstream. Optional OFM_RELU_EN zeroes negative lanes at capture.
module ofm_drain_ctrl
  import ofm_drain_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int SYSTOLIC_SIZE = DEF_SYSTOLIC_SIZE,
  parameter int ARRAY_LAT     = 1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  output logic                                  busy,
  output logic                                  write_out_en,
  output logic                                  reset_pe,
  input  logic [SYSTOLIC_SIZE*DATA_WIDTH*2-1:0] ofm_in,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [SYSTOLIC_SIZE*DATA_WIDTH*2-1:0] out_data,
  output logic [$clog2(SYSTOLIC_SIZE)-1:0]      out_col,
  output drain_state_t                          dbg_state
);

  // Handshake: a column transfers on any cycle with out_valid && out_ready; while out_valid is high
  // and out_ready low, out_data/out_col hold the same FIFO head.

  localparam int LW    = lane_w(DATA_WIDTH);
  localparam int CW    = col_w(SYSTOLIC_SIZE);
  localparam int BUS_W = SYSTOLIC_SIZE * LW;
  localparam int FW    = (ARRAY_LAT > 1) ? $clog2(ARRAY_LAT) : 1;

  drain_state_t         state_q, state_d;
  logic [CW-1:0]        shift_cnt_q, shift_cnt_d;
  logic [FW-1:0]        flush_cnt_q, flush_cnt_d;
  logic                 pend_q, pend_d;
  logic [ARRAY_LAT-1:0] cap_sr;
  logic                 cap_en;
  logic [CW-1:0]        cap_col_q;
  logic [BUS_W-1:0]     lanes;
  logic [BUS_W+CW-1:0]  fifo_rd_data;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 drain_go;

  assign dbg_state = state_q;
  assign drain_go  = (state_q == ST_IDLE) && (start || pend_q) && fifo_empty;

  always_comb begin
    state_d      = state_q;
    shift_cnt_d  = shift_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    write_out_en = 1'b0;
    reset_pe     = 1'b0;
    busy         = 1'b1;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (drain_go) begin
          state_d     = ST_SHIFT;
          shift_cnt_d = '0;
        end
      end
      ST_SHIFT: begin
        write_out_en = 1'b1;
        if (shift_cnt_q == CW'(SYSTOLIC_SIZE - 1)) begin
          state_d     = ST_FLUSH;
          shift_cnt_d = '0;
          flush_cnt_d = '0;
        end else begin
          shift_cnt_d = shift_cnt_q + 1'b1;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_q == FW'(ARRAY_LAT - 1)) state_d = ST_CLEAR;
        else flush_cnt_d = flush_cnt_q + 1'b1;
      end
      ST_CLEAR: begin
        reset_pe = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // One-level pending request: further starts while one is already pending are absorbed.
  always_comb begin
    pend_d = pend_q;
    if (drain_go) pend_d = 1'b0;
    else if (start) pend_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      shift_cnt_q <= '0;
      flush_cnt_q <= '0;
      pend_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_cnt_q <= shift_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      pend_q      <= pend_d;
    end
  end

  // cap_en lines up with the column the array presents ARRAY_LAT cycles after each shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_sr    <= '0;
      cap_col_q <= '0;
    end else begin
      cap_sr[0] <= write_out_en;
      for (int i = 1; i < ARRAY_LAT; i++) cap_sr[i] <= cap_sr[i-1];
      if (cap_en) cap_col_q <= (cap_col_q == CW'(SYSTOLIC_SIZE - 1)) ? '0 : cap_col_q + 1'b1;
    end
  end

  assign cap_en = cap_sr[ARRAY_LAT-1];

  for (genvar r = 0; r < SYSTOLIC_SIZE; r++) begin : g_lane
`ifdef OFM_RELU_EN
    assign lanes[r*LW +: LW] = ofm_in[r*LW + LW - 1] ? '0 : ofm_in[r*LW +: LW];
`else
    assign lanes[r*LW +: LW] = ofm_in[r*LW +: LW];
`endif
  end

  ofm_col_fifo #(
    .WIDTH(BUS_W + CW),
    .DEPTH(SYSTOLIC_SIZE)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (cap_en && !fifo_full),
    .wr_data({cap_col_q, lanes}),
    .rd_en  (out_valid && out_ready),
    .rd_data(fifo_rd_data),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_rd_data[BUS_W-1:0];
  assign out_col   = fifo_rd_data[BUS_W +: CW];

endmodule

// File: tb/tb_ofm_drain_ctrl.sv
// Directed bench for ofm_drain_ctrl: array model, column scoreboard, and a second instance with ARRAY_LAT=3.
module tb_ofm_drain_ctrl;
  import ofm_drain_ctrl_pkg::*;

  localparam int N  = 16;
  localparam int LW = 16;
  localparam int BW = N * LW;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          start, busy, we, rp, out_valid, out_ready;
  logic [BW-1:0] ofm_in, out_data;
  logic [CW-1:0] out_col;
  drain_state_t  dbg_state;

  logic          start2, busy2, we2, rp2, out_valid2, out_ready2;
  logic [BW-1:0] ofm_in2, out_data2;
  logic [CW-1:0] out_col2;
  drain_state_t  dbg_state2;

  int n_checks = 0;
  int n_errors = 0;
  int pattern_mode = 0;
  logic [CW-1:0] exp_q[$];

  ofm_drain_ctrl #(.DATA_WIDTH(8), .SYSTOLIC_SIZE(N), .ARRAY_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .write_out_en(we), .reset_pe(rp),
    .ofm_in(ofm_in), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_col(out_col), .dbg_state(dbg_state)
  );

  ofm_drain_ctrl #(.DATA_WIDTH(8), .SYSTOLIC_SIZE(N), .ARRAY_LAT(3)) dut_lat3 (
    .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .write_out_en(we2), .reset_pe(rp2),
    .ofm_in(ofm_in2), .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
    .out_col(out_col2), .dbg_state(dbg_state2)
  );

  function automatic logic [LW-1:0] raw_lane(input int mode, input int r, input int c);
    if (mode == 1 && r == 0) return 16'hFF80;
    if (mode == 1 && r == 1) return 16'h007F;
    return 16'(16 * r + c);
  endfunction

  function automatic logic [LW-1:0] exp_lane(input int mode, input int r, input int c);
    logic [LW-1:0] v;
    v = raw_lane(mode, r, c);
`ifdef OFM_RELU_EN
    if (v[LW-1]) v = '0;
`endif
    return v;
  endfunction

  function automatic logic [BW-1:0] exp_data(input int c);
    logic [BW-1:0] d;
    for (int r = 0; r < N; r++) d[r*LW +: LW] = exp_lane(pattern_mode, r, c);
    return d;
  endfunction

  function automatic logic [BW-1:0] const2();
    logic [BW-1:0] d;
    for (int r = 0; r < N; r++) d[r*LW +: LW] = 16'hA500 + 16'(r);
    return d;
  endfunction

  // Array model for the ARRAY_LAT=1 instance: each shift presents the next column one cycle later.
  logic [CW-1:0] arr_cnt, arr_col;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arr_cnt <= '0;
      arr_col <= '0;
    end else if (we) begin
      arr_col <= arr_cnt;
      arr_cnt <= arr_cnt + 1'b1;
    end
  end

  always_comb begin
    for (int r = 0; r < N; r++) ofm_in[r*LW +: LW] = raw_lane(pattern_mode, r, int'(arr_col));
  end

  assign ofm_in2 = const2();

  task automatic check_eq(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every accepted beat must match the next expected column.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_extra_beat", 1, 0);
      end else begin
        logic [CW-1:0] c;
        c = exp_q.pop_front();
        check_eq("sb_col", BW'(out_col), BW'(c));
        check_eq("sb_data", out_data, exp_data(int'(c)));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cols(input int copies);
    for (int k = 0; k < copies; k++)
      for (int c = 0; c < N; c++) exp_q.push_back(CW'(c));
  endtask

  task automatic wait_sb(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
    check_eq("sb_drained", BW'(exp_q.size()), 0);
  endtask

  initial begin
    int first_we, last_we, we_cnt, rp_cyc, rp_cnt, first_vld, unstable, beats, seq_bad, data_bad;
    drain_state_t st17;

    rst_n = 1'b0; start = 1'b0; out_ready = 1'b0; start2 = 1'b0; out_ready2 = 1'b1;
    repeat (3) tick();
    check_eq("rst_busy", BW'(busy), 0);
    check_eq("rst_we", BW'(we), 0);
    check_eq("rst_reset_pe", BW'(rp), 0);
    check_eq("rst_out_valid", BW'(out_valid), 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_out_col", BW'(out_col), 0);
    check_eq("rst_state", BW'(dbg_state), BW'(ST_IDLE));
    rst_n = 1'b1;
    tick();

    // Basic drain with ready held high.
    out_ready = 1'b1;
    push_cols(1);
    start = 1'b1;
    check_eq("t1_busy_t0", BW'(busy), 0);
    tick();
    start = 1'b0;
    first_we = -1; last_we = -1; we_cnt = 0; rp_cyc = -1; rp_cnt = 0; first_vld = -1;
    st17 = ST_IDLE;
    for (int k = 1; k <= 24; k++) begin
      if (we) begin
        if (first_we < 0) first_we = k;
        last_we = k;
        we_cnt++;
      end
      if (rp) begin
        rp_cyc = k;
        rp_cnt++;
      end
      if (out_valid && first_vld < 0) first_vld = k;
      if (k == 17) st17 = dbg_state;
      tick();
    end
    check_eq("t1_first_we", BW'(first_we), 1);
    check_eq("t1_last_we", BW'(last_we), 16);
    check_eq("t1_we_cnt", BW'(we_cnt), 16);
    check_eq("t1_rp_cycle", BW'(rp_cyc), 18);
    check_eq("t1_rp_cnt", BW'(rp_cnt), 1);
    check_eq("t1_first_valid", BW'(first_vld), 3);
    check_eq("t1_flush_state", BW'(st17), BW'(ST_FLUSH));
    wait_sb(40);
    check_eq("t1_busy_end", BW'(busy), 0);

    // Backpressure for the whole drain: all 16 columns buffered, head stable.
    out_ready = 1'b0;
    push_cols(1);
    start = 1'b1;
    tick();
    start = 1'b0;
    unstable = 0;
    for (int k = 1; k <= 30; k++) begin
      if (out_valid && (out_col !== '0 || out_data !== exp_data(0))) unstable++;
      tick();
    end
    check_eq("t2_unstable", BW'(unstable), 0);
    check_eq("t2_valid_held", BW'(out_valid), 1);
    check_eq("t2_col0", BW'(out_col), 0);
    check_eq("t2_data0", out_data, exp_data(0));
    check_eq("t2_busy", BW'(busy), 0);
    out_ready = 1'b1;
    wait_sb(40);
    check_eq("t2_valid_after", BW'(out_valid), 0);

    // Start during SHIFT waits for an empty FIFO; a second start while pending is absorbed.
    out_ready = 1'b0;
    push_cols(2);
    start = 1'b1;
    tick();
    start = 1'b0;
    we_cnt = 0;
    for (int k = 1; k <= 39; k++) begin
      start = (k == 5 || k == 25);
      if (k >= 20 && we) we_cnt++;
      tick();
    end
    start = 1'b0;
    check_eq("t3_hold_no_shift", BW'(we_cnt), 0);
    check_eq("t3_hold_busy", BW'(busy), 0);
    out_ready = 1'b1;
    first_we = -1; we_cnt = 0; rp_cnt = 0;
    for (int k = 40; k <= 120; k++) begin
      if (we) begin
        if (first_we < 0) first_we = k;
        we_cnt++;
      end
      if (rp) rp_cnt++;
      tick();
    end
    check_eq("t3_second_first_we", BW'(first_we), 57);
    check_eq("t3_single_drain_we", BW'(we_cnt), 16);
    check_eq("t3_single_drain_rp", BW'(rp_cnt), 1);
    wait_sb(10);

    // Signed lanes: -128 is zeroed only with OFM_RELU_EN, +127 always passes.
    pattern_mode = 1;
    out_ready = 1'b0;
    push_cols(1);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10 && !out_valid; i++) tick();
    check_eq("t4_valid", BW'(out_valid), 1);
`ifdef OFM_RELU_EN
    check_eq("t4_lane0_neg", BW'(out_data[15:0]), 0);
`else
    check_eq("t4_lane0_neg", BW'(out_data[15:0]), BW'(16'hFF80));
`endif
    check_eq("t4_lane1_pos", BW'(out_data[31:16]), BW'(16'h007F));
    check_eq("t4_lane2", BW'(out_data[47:32]), 32);
    out_ready = 1'b1;
    wait_sb(40);
    pattern_mode = 0;
    repeat (5) tick();

    // Reset in the middle of SHIFT (shift_cnt = 7).
    out_ready = 1'b0;
    push_cols(1);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    check_eq("t5_pre_we", BW'(we), 1);
    check_eq("t5_pre_valid", BW'(out_valid), 1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_eq("t5_busy", BW'(busy), 0);
    check_eq("t5_we", BW'(we), 0);
    check_eq("t5_reset_pe", BW'(rp), 0);
    check_eq("t5_valid", BW'(out_valid), 0);
    check_eq("t5_data", out_data, 0);
    check_eq("t5_col", BW'(out_col), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    we_cnt = 0; rp_cnt = 0; beats = 0;
    for (int k = 0; k < 25; k++) begin
      if (we) we_cnt++;
      if (rp) rp_cnt++;
      if (out_valid) beats++;
      tick();
    end
    check_eq("t5_no_reset_pe", BW'(rp_cnt), 0);
    check_eq("t5_no_shift", BW'(we_cnt), 0);
    check_eq("t5_fifo_empty", BW'(beats), 0);
    out_ready = 1'b1;
    push_cols(1);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_sb(40);

    // ARRAY_LAT=3 instance: 16 captures, first valid 4 cycles after SHIFT entry.
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    first_vld = -1; beats = 0; seq_bad = 0; data_bad = 0; we_cnt = 0; rp_cyc = -1; rp_cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      if (out_valid2) begin
        if (first_vld < 0) first_vld = k;
        if (out_col2 !== CW'(beats)) seq_bad++;
        if (out_data2 !== const2()) data_bad++;
        beats++;
      end
      if (we2) we_cnt++;
      if (rp2) begin
        rp_cyc = k;
        rp_cnt++;
      end
      tick();
    end
    check_eq("t6_first_valid", BW'(first_vld), 5);
    check_eq("t6_beats", BW'(beats), 16);
    check_eq("t6_col_seq", BW'(seq_bad), 0);
    check_eq("t6_data", BW'(data_bad), 0);
    check_eq("t6_we_cnt", BW'(we_cnt), 16);
    check_eq("t6_rp_cycle", BW'(rp_cyc), 20);
    check_eq("t6_rp_cnt", BW'(rp_cnt), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
